cva6_counter_csr_ctrl: RTL
==========================

Name: cva6_counter_csr_ctrl

Overview:
CSR-side access controller for a bank of NumCounters hardware performance counters. It serves CSR read and write requests through a valid/ready request port and a valid/ready response port. It drives the per-counter increment, write-enable and write-data inputs, and reads back each counter's 64-bit value. It also generates gated increments from event inputs and tracks sticky per-counter overflow flags. It sits between the CSR file and the counter instances.

Parameters:
NumCounters, 8, number of counters controlled (1..32)
CounterWidth, 64, implemented counter bits (1..64); bits above this read as zero
XLEN, 64, CSR data width (32 or 64)
IdxW, $clog2(NumCounters) (min 1), width of the counter index field (derived)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active-low
req_valid_i  in  1  CSR request valid
req_ready_o  out  1  request accepted when valid&ready
req_we_i  in  1  1 = write, 0 = read
req_idx_i  in  IdxW  counter index
req_hi_i  in  1  XLEN=32 only: access bits [63:32]; ignored when XLEN=64
req_wdata_i  in  XLEN  write data
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed
rsp_rdata_o  out  XLEN  counter value sampled at the accept cycle
rsp_err_o  out  1  index >= NumCounters
event_i  in  NumCounters  per-counter event pulse
inhibit_i  in  NumCounters  per-counter increment inhibit (mcountinhibit)
ovf_clr_i  in  NumCounters  clear sticky overflow bits
overflow_o  out  NumCounters  sticky overflow flags
counter_inc_o  out  NumCounters  to counter inc inputs
counter_we_o  out  NumCounters  to counter we inputs
counter_wval_o  out  64  shared write value to all counters
counter_val_i  in  NumCounters*64  counter outputs, counter k at [64k+63:64k]

Behaviour:
- Reset values: asynchronous, rst_ni low. rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, overflow_o=0, req_ready_o=1. counter_we_o and counter_inc_o are combinational; with req_valid_i=0 and event_i=0 both are 0.
- Acceptance (one-stage pipeline):
  - req_ready_o = !rsp_valid_o | rsp_ready_i.
  - On accept, the response register loads and rsp_valid_o=1 on the next edge.
  - The response holds stable until rsp_ready_i. Back-to-back requests run at 1 per cycle when rsp_ready_i=1.
- Read data:
  - rsp_rdata_o captures the counter value at the accept cycle, before any write or increment in that cycle takes effect.
  - XLEN=64: full 64 bits. XLEN=32: bits [63:32] if req_hi_i, else [31:0].
  - Writes also return the old value (csrrw semantics).
- Write:
  - counter_we_o[idx] pulses in the accept cycle only (combinational on valid&ready&we).
  - counter_wval_o for XLEN=64: req_wdata_i.
  - counter_wval_o for XLEN=32, lo access: {cur[63:32], wdata}. Hi access: {wdata, cur[31:0]}.
  - Bits >= CounterWidth are don't-care; the counter discards them.
- Out-of-range index (idx >= NumCounters): no counter_we_o asserted; rsp_rdata_o=0, rsp_err_o=1. In-range requests have rsp_err_o=0.
- Increment: counter_inc_o[k] = event_i[k] & ~inhibit_i[k] & ~counter_we_o[k]. A write in the same cycle wins; the event is dropped.
- Overflow:
  - overflow_o[k] sets on the edge where counter_inc_o[k]=1 and cur[CounterWidth-1:0] is all ones (wrap to 0).
  - ovf_clr_i[k] clears the bit. A simultaneous set and clear leaves the bit set.
  - A write never sets overflow.
- Reset mid-response: the pending response is discarded with no replay. Counters are reset by their own instances.
- Idle cycles (req_valid_i=0) drive no counter writes.

Test Plan:
- Read: counter 3 value 0x0000_0001_2345_6789, XLEN=64, read idx 3 -> one cycle later rsp_valid_o=1, rdata=0x0000000123456789, err=0.
- RV32 half write: XLEN=32, counter 2 = 0xAAAA_BBBB_CCCC_DDDD, write hi wdata=0x1111_2222 -> counter_we_o[2] for 1 cycle, counter_wval_o=0x11112222CCCCDDDD, rdata=0xAAAABBBB.
- Write vs event collision: event_i[1]=1 in the same cycle as a write of 0x10 to idx 1 -> counter_inc_o[1]=0, counter reads 0x10 next cycle. An inhibited counter with event_i=1 shows counter_inc_o=0.
- Overflow: CounterWidth=48, counter 0 = 0xFFFF_FFFF_FFFF, event -> counter wraps to 0, overflow_o[0]=1. It stays set until ovf_clr_i[0]=1; with set and clear in the same cycle it stays 1.
- Backpressure: rsp_ready_i=0 for 3 cycles with a second request pending -> req_ready_o=0, rdata stable. On release both responses arrive in order.
- Out-of-range and reset: NumCounters=6, read idx 7 -> rdata=0, err=1, no counter_we_o. Assert rst_ni while rsp_valid_o=1 -> rsp_valid_o=0 and overflow_o=0 immediately.

Source files
------------

// File: rtl/cva6_counter_csr_ctrl.sv
// CSR-side access controller for a bank of hardware performance counters.
// Serves CSR reads/writes through a one-stage request/response pipeline,
// drives the counter write/increment strobes and tracks sticky overflow.
//
// Handshake: a request transfers on a clock edge where req_valid_i and
// req_ready_o are both high; a response transfers on an edge where
// rsp_valid_o and rsp_ready_i are both high. A presented response holds
// rsp_rdata_o/rsp_err_o stable until it transfers, and a new request is
// accepted in the same cycle the previous response is consumed.
module cva6_counter_csr_ctrl #(
  parameter int unsigned NumCounters  = 8,
  parameter int unsigned CounterWidth = 64,
  parameter int unsigned XLEN         = 64,
  parameter int unsigned IdxW         = (NumCounters > 1) ? $clog2(NumCounters) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_we_i,
  input  logic [IdxW-1:0]           req_idx_i,
  input  logic                      req_hi_i,
  input  logic [XLEN-1:0]           req_wdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [XLEN-1:0]           rsp_rdata_o,
  output logic                      rsp_err_o,
  input  logic [NumCounters-1:0]    event_i,
  input  logic [NumCounters-1:0]    inhibit_i,
  input  logic [NumCounters-1:0]    ovf_clr_i,
  output logic [NumCounters-1:0]    overflow_o,
  output logic [NumCounters-1:0]    counter_inc_o,
  output logic [NumCounters-1:0]    counter_we_o,
  output logic [63:0]               counter_wval_o,
  input  logic [NumCounters*64-1:0] counter_val_i
);

  // Bits of a counter that are actually implemented; the rest read as zero.
  localparam logic [63:0] CntMask = (CounterWidth >= 64) ? {64{1'b1}} :
                                    ((64'd1 << CounterWidth) - 64'd1);

  logic [63:0]            cnt_val [NumCounters];
  logic                   accept;
  logic                   idx_in_range;
  logic [63:0]            cur_raw;
  logic [63:0]            cur;
  logic [XLEN-1:0]        rd_sel;
  logic [63:0]            wval;
  logic [NumCounters-1:0] we;
  logic [NumCounters-1:0] inc;
  logic [NumCounters-1:0] wrap;

  logic                   rsp_valid_d, rsp_valid_q;
  logic [XLEN-1:0]        rsp_rdata_d, rsp_rdata_q;
  logic                   rsp_err_d, rsp_err_q;
  logic [NumCounters-1:0] overflow_d, overflow_q;

  for (genvar g = 0; g < NumCounters; g++) begin : g_unpack
    assign cnt_val[g] = counter_val_i[g*64 +: 64];
  end

  // The pipeline stage frees up when empty or when its response leaves now.
  assign req_ready_o  = !rsp_valid_q || rsp_ready_i;
  assign accept       = req_valid_i && req_ready_o;
  assign idx_in_range = ({1'b0, req_idx_i} < (IdxW+1)'(NumCounters));

  // Select the addressed counter; an out-of-range index matches nothing.
  always_comb begin
    cur_raw = '0;
    for (int unsigned k = 0; k < NumCounters; k++) begin
      if (req_idx_i == IdxW'(k)) cur_raw = cnt_val[k];
    end
    cur = idx_in_range ? (cur_raw & CntMask) : '0;
  end

  if (XLEN == 64) begin : g_rv64
    logic unused_hi;
    assign unused_hi = req_hi_i;
    assign rd_sel    = cur;
    assign wval      = req_wdata_i;
  end else begin : g_rv32
    // RV32 accesses one half; a write keeps the other half of the counter.
    assign rd_sel = req_hi_i ? cur[63:32] : cur[31:0];
    assign wval   = req_hi_i ? {req_wdata_i, cur[31:0]} : {cur[63:32], req_wdata_i};
  end

  assign counter_wval_o = wval;

  // Write strobes only in the accept cycle; a write beats a same-cycle event.
  always_comb begin
    we   = '0;
    wrap = '0;
    for (int unsigned k = 0; k < NumCounters; k++) begin
      we[k]   = accept && req_we_i && (req_idx_i == IdxW'(k));
      wrap[k] = ((cnt_val[k] & CntMask) == CntMask);
    end
    inc = event_i & ~inhibit_i & ~we;
  end

  assign counter_we_o  = we;
  assign counter_inc_o = inc;

  // Response register loads on accept and drops once consumed; overflow is
  // sticky, with a same-cycle set taking priority over a clear.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = idx_in_range ? rd_sel : '0;
      rsp_err_d   = !idx_in_range;
    end else if (rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end
    overflow_d = (overflow_q & ~ovf_clr_i) | (inc & wrap);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      overflow_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      overflow_q  <= overflow_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign overflow_o  = overflow_q;

endmodule
